// File: rtl/s4ga_array.sv
// s4ga_array: N serially configured K-input LUTs fed by each other and by external inputs.
// Optional macro S4GA_ARRAY_SYNC_EN: updates collect in a shadow array, committed once per frame.
module s4ga_array #(
    parameter int N     = 61,
    parameter int K     = 4,
    parameter int SI_W  = 4,
    parameter int EXT_W = 4,
    parameter int OUT_W = 8
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_si_valid,
    input  logic [SI_W-1:0]                     i_si,
    input  logic [((EXT_W > 0) ? EXT_W : 1)-1:0] i_ext_in,
    output logic [OUT_W-1:0]                    o_lut_out,
    output logic [$clog2(N)-1:0]                o_lut_idx,
    output logic                                o_frame_done
);

    localparam int IDX_W     = $clog2(N + EXT_W);
    localparam int MASK_W    = 2 ** K;
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
    localparam int SH_SEGS   = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
    localparam int SH_W      = SH_SEGS * SI_W;
    localparam int SHI_W     = $clog2(SH_W);
    localparam int SEG_W     = $clog2(SH_SEGS + 1);
    localparam int KC_W      = $clog2(K + 1);
    localparam int LIDX_W    = $clog2(N);

    localparam logic [0:0] LOAD_IDX  = 1'b0;
    localparam logic [0:0] LOAD_MASK = 1'b1;

    logic [0:0]        r_state;
    logic [KC_W-1:0]   r_k;
    logic [SEG_W-1:0]  r_seg;
    logic [SH_W-1:0]   r_shift;
    logic [K-1:0]      r_addr;
    logic [LIDX_W-1:0] r_idx;
    logic [N-1:0]      r_lut;
    logic              r_frame_done;
`ifdef S4GA_ARRAY_SYNC_EN
    logic [N-1:0]      r_shadow;
`endif

    logic [SH_W-1:0]   w_shift_nxt;
    logic              w_field_end;
    logic              w_rec_done;
    logic              w_last_lut;
    logic              w_sel_bit;
    logic              w_new_bit;
    logic [N-1:0]      w_lut_upd;

    // The shift register is cleared at every field boundary, so it holds only the current field.
    always_comb begin
        w_shift_nxt = (r_shift << SI_W) | SH_W'(i_si);
        w_field_end = i_si_valid &&
                      (r_seg == ((r_state == LOAD_IDX) ? SEG_W'(IDX_SEGS - 1) : SEG_W'(MASK_SEGS - 1)));
        w_rec_done  = w_field_end && (r_state == LOAD_MASK);
        w_last_lut  = (r_idx == LIDX_W'(N - 1));
        w_new_bit   = w_shift_nxt[SHI_W'(r_addr)];
    end

    // Out-of-range index values read constant 0.
    always_comb begin
        w_sel_bit = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (w_shift_nxt == SH_W'(j)) w_sel_bit = r_lut[j];
        end
        for (int j = 0; j < EXT_W; j++) begin
            if (w_shift_nxt == SH_W'(N + j)) w_sel_bit = i_ext_in[j];
        end
    end

    always_comb begin
`ifdef S4GA_ARRAY_SYNC_EN
        w_lut_upd = r_shadow;
`else
        w_lut_upd = r_lut;
`endif
        w_lut_upd[r_idx] = w_new_bit;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= LOAD_IDX;
            r_k          <= '0;
            r_seg        <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_idx        <= '0;
            r_lut        <= '0;
            r_frame_done <= 1'b0;
`ifdef S4GA_ARRAY_SYNC_EN
            r_shadow     <= '0;
`endif
        end else begin
            r_frame_done <= w_rec_done && w_last_lut;
            if (i_si_valid) begin
                if (w_field_end) begin
                    r_seg   <= '0;
                    r_shift <= '0;
                    if (r_state == LOAD_IDX) begin
                        // First index field lands in the address MSB after K shifts.
                        r_addr <= K'({r_addr, w_sel_bit});
                        r_k    <= r_k + 1'b1;
                        if (r_k == KC_W'(K - 1)) r_state <= LOAD_MASK;
                    end else begin
                        r_state <= LOAD_IDX;
                        r_k     <= '0;
                        r_idx   <= w_last_lut ? '0 : r_idx + 1'b1;
`ifdef S4GA_ARRAY_SYNC_EN
                        r_shadow <= w_lut_upd;
                        if (w_last_lut) r_lut <= w_lut_upd;
`else
                        r_lut <= w_lut_upd;
`endif
                    end
                end else begin
                    r_seg   <= r_seg + 1'b1;
                    r_shift <= w_shift_nxt;
                end
            end
        end
    end

    assign o_lut_out    = r_lut[OUT_W-1:0];
    assign o_lut_idx    = r_idx;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_s4ga_array.sv
// Scoreboard bench for s4ga_array: reference model of LUT records, monitor checks each update.
module tb_s4ga_array;

    localparam int N         = 3;
    localparam int K         = 2;
    localparam int SI_W      = 4;
    localparam int EXT_W     = 2;
    localparam int OUT_W     = 3;
    localparam int IDX_W     = $clog2(N + EXT_W);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
    localparam int LIDX_W    = $clog2(N);

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              si_valid = 1'b0;
    logic [SI_W-1:0]   si       = '0;
    logic [EXT_W-1:0]  ext_in   = '0;
    logic [OUT_W-1:0]  o_lut_out;
    logic [LIDX_W-1:0] o_lut_idx;
    logic              o_frame_done;

    s4ga_array #(.N(N), .K(K), .SI_W(SI_W), .EXT_W(EXT_W), .OUT_W(OUT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_si_valid(si_valid), .i_si(si), .i_ext_in(ext_in),
        .o_lut_out(o_lut_out), .o_lut_idx(o_lut_idx), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0]  out;
        logic [LIDX_W-1:0] idx;
        logic              fd;
    } exp_t;

    exp_t exp_q[$];
    bit   vis[N];
    bit   sh[N];
    int   cur;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit ref_sel(input int v);
        if (v < N) return vis[v];
        if (v < N + EXT_W) return ext_in[v - N];
        return 1'b0;
    endfunction

    // Reference: first index is the address MSB; mask bit at that address becomes the LUT value.
    task automatic model_record(input int i0, input int i1, input int mask);
        int   addr;
        bit   newv;
        exp_t e;
        addr = (int'(ref_sel(i0)) << 1) | int'(ref_sel(i1));
        newv = ((mask >> addr) & 1) != 0;
`ifdef S4GA_ARRAY_SYNC_EN
        sh[cur] = newv;
        if (cur == N - 1) vis = sh;
`else
        vis[cur] = newv;
`endif
        for (int j = 0; j < OUT_W; j++) e.out[j] = vis[j];
        e.idx = LIDX_W'((cur + 1) % N);
        e.fd  = (cur == N - 1);
        exp_q.push_back(e);
        cur = (cur + 1) % N;
    endtask

    task automatic send_seg(input logic [SI_W-1:0] s, input int gap);
        repeat (gap) begin
            si_valid = 1'b0;
            si       = SI_W'($urandom);
            @(posedge clk); #1;
        end
        si_valid = 1'b1;
        si       = s;
        @(posedge clk); #1;
        si_valid = 1'b0;
    endtask

    task automatic send_field(input int v, input int nsegs, input int gapmax);
        for (int s = nsegs - 1; s >= 0; s--)
            send_seg(SI_W'(v >> (s * SI_W)), $urandom_range(0, gapmax));
    endtask

    task automatic send_record(input int i0, input int i1, input int mask, input int gapmax);
        model_record(i0, i1, mask);
        send_field(i0, IDX_SEGS, gapmax);
        send_field(i1, IDX_SEGS, gapmax);
        send_field(mask, MASK_SEGS, gapmax);
    endtask

    // Reset is raised mid-cycle so its effect on the outputs can be seen without a clock edge.
    task automatic do_reset();
        @(negedge clk); #1;
        check("pending_before_reset", exp_q.size(), 0);
        rst = 1'b1;
        #1;
        check("rst_lut_out", int'(o_lut_out), 0);
        check("rst_lut_idx", int'(o_lut_idx), 0);
        check("rst_frame_done", int'(o_frame_done), 0);
        for (int j = 0; j < N; j++) begin
            vis[j] = 1'b0;
            sh[j]  = 1'b0;
        end
        cur = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [LIDX_W-1:0] prev_idx;
    logic [OUT_W-1:0]  cur_out;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_idx = '0;
            cur_out  = '0;
        end else if (o_lut_idx !== prev_idx) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_update: lut_idx %0d, expected no record pending", o_lut_idx);
            end else begin
                e = exp_q.pop_front();
                check("upd_lut_out", int'(o_lut_out), int'(e.out));
                check("upd_lut_idx", int'(o_lut_idx), int'(e.idx));
                check("upd_frame_done", int'(o_frame_done), int'(e.fd));
                cur_out = e.out;
            end
            prev_idx = o_lut_idx;
        end else begin
            check("idle_frame_done", int'(o_frame_done), 0);
            check("idle_lut_out", int'(o_lut_out), int'(cur_out));
        end
    end

    initial begin
        #2;
        do_reset();

        ext_in = 2'b11; send_record(3, 4, 4'h8, 0);
        do_reset();
        ext_in = 2'b01; send_record(3, 4, 4'h8, 0);
        do_reset();
        ext_in = 2'b11; send_record(3, 4, 4'h8, 2);

        do_reset();
        repeat (3) send_record(5, 5, 4'h1, 0);
        send_record(5, 5, 4'h1, 1);

        do_reset();
        repeat (2) begin
            send_record(5, 5, 4'h1, 1);
            send_record(0, 0, 4'h8, 1);
            send_record(7, 6, 4'h6, 0);
        end

        do_reset();
        send_record(5, 5, 4'h1, 0);
        send_seg(SI_W'(0), 0);
        send_seg(SI_W'(0), 1);
        do_reset();
        send_record(5, 5, 4'h1, 0);
        send_record(0, 9, 4'hA, 0);
        send_record(1, 0, 4'hE, 0);

        do_reset();
        for (int r = 0; r < 60; r++) begin
            ext_in = EXT_W'($urandom);
            send_record($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 15), 2);
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
